// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Front end of the 9-bit accumulator core. Holds instruction memory and the
//   branch-target table, runs the program counter, presents the current
//   instruction to the control decoder and consumes its Branch/Halt verdict.
//   A host load port fills memory/table while the core is not running.
//
// Ports
//   i_clk            clock, all state on rising edge
//   i_reset_n        synchronous reset, active-low
//   i_start          begin execution at PC 0 (IDLE or HALTED only)
//   i_load_valid     host write request
//   o_load_ready     writes accepted (IDLE or HALTED)
//   i_load_is_target 1 = branch-target table, 0 = instruction memory
//   i_load_addr      write address (low table-index bits for table writes)
//   i_load_data      write data (imem keeps low INST_W bits)
//   o_inst           current instruction, HALT encoding outside RUN
//   o_inst_valid     high in RUN
//   i_branch         decoder: take branch this cycle
//   i_halt           decoder: stop (beats branch)
//   o_pc             program counter
//   o_done           high in HALTED
//   o_overrun        sticky: PC ran off the end of memory
//   o_inst_count     instructions retired this run, saturating
//
// State table
//   S_IDLE   | after reset, waiting for start, loads accepted
//   S_RUN    | one instruction per cycle, loads dropped
//   S_HALTED | stopped by halt or overrun, loads accepted, done asserted

module instr_fetch_unit #(
    parameter int PC_W   = 10,
    parameter int INST_W = 9,
    parameter int LUT_N  = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic              i_load_is_target,
    input  logic [PC_W-1:0]   i_load_addr,
    input  logic [PC_W-1:0]   i_load_data,
    output logic [INST_W-1:0] o_inst,
    output logic              o_inst_valid,
    input  logic              i_branch,
    input  logic              i_halt,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_done,
    output logic              o_overrun,
    output logic [CNT_W-1:0]  o_inst_count
);

    localparam int LUT_W = $clog2(LUT_N);
    localparam logic [INST_W-1:0] INST_HALT = INST_W'(9'h1E0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic              r_overrun;
    logic              w_overrun_nxt;
    logic [CNT_W-1:0]  r_inst_count;
    logic [CNT_W-1:0]  w_inst_count_nxt;

    logic [INST_W-1:0] r_imem [2**PC_W];
    logic [PC_W-1:0]   r_lut  [LUT_N];

    logic              w_run;
    logic [INST_W-1:0] w_inst;
    logic              w_load_fire;

    assign w_run        = (r_state == S_RUN);
    assign w_inst       = w_run ? r_imem[r_pc] : INST_HALT;
    assign w_load_fire  = i_load_valid & ~w_run;

    assign o_load_ready = ~w_run;
    assign o_inst       = w_inst;
    assign o_inst_valid = w_run;
    assign o_pc         = r_pc;
    assign o_done       = (r_state == S_HALTED);
    assign o_overrun    = r_overrun;
    assign o_inst_count = r_inst_count;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_overrun_nxt    = r_overrun;
        w_inst_count_nxt = r_inst_count;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (i_start) begin
                    w_state_nxt      = S_RUN;
                    w_pc_nxt         = '0;
                    w_overrun_nxt    = 1'b0;
                    w_inst_count_nxt = '0;
                end
            end
            S_RUN: begin
                // every RUN cycle retires an instruction, including the halting one
                if (r_inst_count != '1) begin
                    w_inst_count_nxt = r_inst_count + CNT_W'(1);
                end
                if (i_halt) begin
                    w_state_nxt = S_HALTED;
                end else if (i_branch) begin
                    w_pc_nxt = r_lut[w_inst[LUT_W-1:0]];
                end else if (r_pc == '1) begin
                    // no wrap: falling off the end stops the core and flags it
                    w_state_nxt   = S_HALTED;
                    w_overrun_nxt = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + PC_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_overrun    <= 1'b0;
            r_inst_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_overrun    <= w_overrun_nxt;
            r_inst_count <= w_inst_count_nxt;
        end
    end

    // Storage is deliberately not reset so a program survives a mid-run reset.
    always_ff @(posedge i_clk) begin
        if (w_load_fire) begin
            if (i_load_is_target) begin
                r_lut[i_load_addr[LUT_W-1:0]] <= i_load_data;
            end else begin
                r_imem[i_load_addr] <= i_load_data[INST_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int PC_W   = 10;
    localparam int INST_W = 9;
    // Narrow counter so a full-memory run (1024 instructions) reaches saturation.
    localparam int CNT_W  = 10;

    localparam logic [8:0] I_ADD  = 9'h020;
    localparam logic [8:0] I_ADDI = 9'h040;
    localparam logic [8:0] I_SUB  = 9'h060;
    localparam logic [8:0] I_HALT = 9'h1E0;
    localparam logic [8:0] I_BR5  = 9'h185;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              load_valid;
    logic              load_ready;
    logic              load_is_target;
    logic [PC_W-1:0]   load_addr;
    logic [PC_W-1:0]   load_data;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic              branch;
    logic              halt;
    logic [PC_W-1:0]   pc;
    logic              done;
    logic              overrun;
    logic [CNT_W-1:0]  inst_count;

    int n_checks = 0;
    int n_fail   = 0;
    int run_cycles;

    logic [8:0] prog1 [4];

    instr_fetch_unit #(
        .PC_W  (PC_W),
        .INST_W(INST_W),
        .LUT_N (32),
        .CNT_W (CNT_W)
    ) u_dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_start         (start),
        .i_load_valid    (load_valid),
        .o_load_ready    (load_ready),
        .i_load_is_target(load_is_target),
        .i_load_addr     (load_addr),
        .i_load_data     (load_data),
        .o_inst          (inst),
        .o_inst_valid    (inst_valid),
        .i_branch        (branch),
        .i_halt          (halt),
        .o_pc            (pc),
        .o_done          (done),
        .o_overrun       (overrun),
        .o_inst_count    (inst_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic tgt, input logic [PC_W-1:0] addr, input logic [PC_W-1:0] data);
        load_valid     = 1'b1;
        load_is_target = tgt;
        load_addr      = addr;
        load_data      = data;
        tick();
        load_valid     = 1'b0;
        load_is_target = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_is_target = 1'b0;
        load_addr = '0; load_data = '0; branch = 1'b0; halt = 1'b0;
        prog1[0] = I_ADD; prog1[1] = I_ADDI; prog1[2] = I_SUB; prog1[3] = I_HALT;

        tick(); tick();
        reset_n = 1'b1;
        check_eq("rst_pc", pc, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_count", inst_count, 0);
        check_eq("rst_valid", inst_valid, 0);
        check_eq("rst_ready", load_ready, 1);
        check_eq("rst_inst", inst, 32'h1E0);

        // straight-line program ending in HALT at PC 3
        for (int i = 0; i < 4; i++) load(1'b0, PC_W'(i), {1'b0, prog1[i]});
        pulse_start();
        check_eq("t1_valid", inst_valid, 1);
        check_eq("t1_ready_run", load_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_pc", pc, i);
            check_eq("t1_inst", inst, prog1[i]);
            check_eq("t1_count", inst_count, i);
            if (i == 3) halt = 1'b1;
            tick();
            halt = 1'b0;
        end
        check_eq("t1_done", done, 1);
        check_eq("t1_pc_hold", pc, 3);
        check_eq("t1_count_end", inst_count, 4);
        check_eq("t1_valid_off", inst_valid, 0);
        check_eq("t1_inst_off", inst, 32'h1E0);
        check_eq("t1_ready_halted", load_ready, 1);
        tick();
        check_eq("t1_pc_stay", pc, 3);
        check_eq("t1_done_stay", done, 1);

        // branch through table entry 5
        load(1'b1, 10'd5, 10'h040);
        load(1'b0, 10'd0, {1'b0, I_ADD});
        load(1'b0, 10'd1, {1'b0, I_BR5});
        load(1'b0, 10'h040, {1'b0, I_HALT});
        pulse_start();
        check_eq("t2_pc0", pc, 0);
        check_eq("t2_count0", inst_count, 0);
        tick();
        check_eq("t2_pc1", pc, 1);
        check_eq("t2_inst1", inst, 32'h185);
        check_eq("t2_count1", inst_count, 1);
        branch = 1'b1;
        tick();
        branch = 1'b0;
        check_eq("t2_pc_target", pc, 32'h040);
        check_eq("t2_count2", inst_count, 2);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_eq("t2_done", done, 1);
        check_eq("t2_count3", inst_count, 3);

        // halt beats branch at PC 7; load and start during RUN are ignored
        for (int i = 0; i < 7; i++) load(1'b0, PC_W'(i), {1'b0, I_ADD});
        load(1'b0, 10'd7, {1'b0, I_BR5});
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            check_eq("t3_pc", pc, i);
            if (i == 2) begin
                load_valid = 1'b1; load_addr = '0; load_data = {1'b0, I_HALT};
                check_eq("t3_ready_run", load_ready, 0);
            end
            if (i == 4) start = 1'b1;
            if (i == 7) begin branch = 1'b1; halt = 1'b1; end
            tick();
            load_valid = 1'b0; start = 1'b0; branch = 1'b0; halt = 1'b0;
        end
        check_eq("t3_done", done, 1);
        check_eq("t3_pc_nojump", pc, 7);
        check_eq("t3_count", inst_count, 8);

        // mid-run reset at PC 9
        for (int i = 7; i < 12; i++) load(1'b0, PC_W'(i), {1'b0, I_ADD});
        pulse_start();
        check_eq("t5_imem0_kept", inst, I_ADD);
        for (int i = 0; i < 9; i++) begin
            check_eq("t5_pc", pc, i);
            tick();
        end
        check_eq("t5_pc9", pc, 9);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("t5_rst_pc", pc, 0);
        check_eq("t5_rst_count", inst_count, 0);
        check_eq("t5_rst_valid", inst_valid, 0);
        check_eq("t5_rst_inst", inst, 32'h1E0);
        check_eq("t5_rst_done", done, 0);
        // load and start on the same edge: RUN sees the new word
        load_valid = 1'b1; load_addr = '0; load_data = 10'h0A5; start = 1'b1;
        tick();
        load_valid = 1'b0; start = 1'b0;
        check_eq("t5_ls_valid", inst_valid, 1);
        check_eq("t5_ls_pc", pc, 0);
        check_eq("t5_ls_inst", inst, 32'h0A5);
        tick();
        check_eq("t5_kept_pc", pc, 1);
        check_eq("t5_kept_inst", inst, I_ADD);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_eq("t5_done", done, 1);

        // run off the end of memory
        for (int a = 0; a < 1024; a++) load(1'b0, PC_W'(a), {1'b0, I_ADD});
        pulse_start();
        run_cycles = 0;
        for (int c = 0; c < 1100 && !done; c++) begin
            if (inst_valid) run_cycles++;
            tick();
        end
        check_eq("t4_done", done, 1);
        check_eq("t4_overrun", overrun, 1);
        check_eq("t4_pc_last", pc, 1023);
        check_eq("t4_cycles", run_cycles, 1024);
        check_eq("t4_count_sat", inst_count, 1023);
        load(1'b0, 10'd0, {1'b0, I_HALT});
        pulse_start();
        check_eq("t4_overrun_clr", overrun, 0);
        check_eq("t4_new_inst", inst, 32'h1E0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_eq("t4_done2", done, 1);
        check_eq("t4_count2", inst_count, 1);
        check_eq("t4_overrun_stay0", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 9-bit accumulator core; the producer side of the instruction/control interface.
- Holds instruction memory and a 32-entry branch-target table, and runs the program counter.
- Presents Inst to the control decoder, then consumes the decoder's Branch and Halt outputs to pick the next PC.
- Also provides the program-load port used by the testbench/host before each run.

Parameters:
PC_W, 10, program counter width; instruction memory depth = 2**PC_W.
INST_W, 9, instruction width; opcode = Inst[8:5], operand = Inst[4:0].
LUT_N, 32, branch-target table entries, indexed by Inst[4:0].
CNT_W, 16, executed-instruction counter width.

Ports:
Clk  in  1  clock, all state on rising edge.
Reset_n  in  1  synchronous reset, active-low.
Start  in  1  begin execution at PC 0 (accepted in IDLE or HALTED only).
LoadValid  in  1  host write request.
LoadReady  out  1  high when writes are accepted (IDLE or HALTED).
LoadIsTarget  in  1  1 = write branch-target table, 0 = write instruction memory.
LoadAddr  in  PC_W  write address; low 5 bits only when LoadIsTarget=1.
LoadData  in  PC_W  write data; instruction memory keeps low INST_W bits, table keeps all PC_W bits.
Inst  out  INST_W  current instruction to the decoder.
InstValid  out  1  high in RUN only.
Branch  in  1  from the decoder: take the branch this cycle.
Halt  in  1  from the decoder: stop.
PC  out  PC_W  current program counter.
Done  out  1  high in HALTED.
Overrun  out  1  sticky; set when PC runs off the end of memory.
InstCount  out  CNT_W  instructions retired in the current run, saturating.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-low (Reset_n sampled on the Clk rising edge).
- Reset values:
  - state IDLE; PC=0; Done=0; Overrun=0; InstCount=0; InstValid=0; LoadReady=1.
  - Memory and table contents are not reset.
  - Reset asserted mid-RUN returns to IDLE on the next edge. Memory contents survive.
- States: IDLE, RUN, HALTED.
  - IDLE/HALTED --Start--> RUN: PC<=0, InstCount<=0, Overrun<=0, Done<=0.
  - Start while in RUN is ignored.
- Instruction read: combinational, Inst = imem[PC] in RUN. Outside RUN, Inst is forced to 9'h1E0 (HALT encoding) with InstValid=0. Branch/Halt are ignored outside RUN.
- One instruction per cycle in RUN. Next-PC priority:
  - Halt=1: state<=HALTED, PC holds, InstCount increments. Halt beats Branch.
  - else Branch=1: PC <= lut[Inst[4:0]].
  - else if PC == 2**PC_W-1: state<=HALTED, Overrun<=1, PC holds.
  - else PC <= PC+1.
- InstCount: +1 per RUN cycle, saturating at all-ones; it does not wrap.
- Branch to the current PC (self-loop) is legal and runs until reset.
- Load port:
  - A write occurs on an edge where LoadValid & LoadReady.
  - LoadReady = (state != RUN). LoadValid in RUN is dropped, with no effect.
  - Load and Start on the same edge in IDLE: the write commits, and RUN then begins reading the written contents on the next cycle.
- Latency: Start edge -> first InstValid cycle = 1; Halt edge -> Done=1 on the next cycle.

Test Plan:
- Load imem[0..3] = ADD, ADDI, SUB, 0x1E0 (HALT); pulse Start; decoder Halt on PC=3 -> PC sequence 0,1,2,3; Done=1 one cycle after PC=3; InstCount=4; PC stays 3.
- Load lut[5]=0x040, imem[1]=0x185 (BRANCH 5); run -> PC goes 0,1,0x040; InstCount increments every cycle.
- Branch=1 and Halt=1 in the same cycle at PC=7 -> HALTED, PC=7, no jump taken.
- Fill imem with ADD (no halt), PC_W=4 -> PC reaches 15, then HALTED with Overrun=1, InstCount=16. A later Start clears Overrun.
- During RUN, assert LoadValid to imem[0] with new data -> LoadReady=0, imem[0] unchanged after halt (read back by re-running).
- Drop Reset_n low for one cycle mid-RUN at PC=9 -> next cycle IDLE, PC=0, InstCount=0, InstValid=0, Inst=0x1E0; program contents intact on the next Start.
